// File: rtl/pe_ctrl_pkg.sv
// Shared geometry, widths and FSM encoding for the single-PE 3x3 convolution sequencer.
package pe_ctrl_pkg;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int K      = 3;
    localparam int CIN    = 3;
    localparam int COUT   = 3;
    localparam int ACC_W  = 16;
    localparam int IFM_AW = 12;
    localparam int WGT_AW = 7;
    localparam int OFM_AW = 12;
    localparam int PE_LAT = 1;

    localparam int OUT_W        = IMG_W - K + 1;
    localparam int OUT_H        = IMG_H - K + 1;
    localparam int MACS_PER_PIX = CIN * K * K;
    localparam int PLANE        = IMG_H * IMG_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/pe_conv_sequencer_if.sv
// Control/SRAM/PE signal bundle; master is the sequencer, slave is the surrounding system.
interface pe_conv_sequencer_if;
    import pe_ctrl_pkg::*;

    // start is a single-cycle request honoured only in IDLE; busy/done report progress.
    // Read enables and addresses are valid in the cycle they are high; SRAM data
    // returns one cycle later, aligned with pe_mac_en.
    logic              start;
    logic              busy;
    logic              done;
    logic              ifm_rd;
    logic [IFM_AW-1:0] ifm_addr;
    logic              wgt_rd;
    logic [WGT_AW-1:0] wgt_addr;
    logic              pe_acc_clr;
    logic              pe_mac_en;
    logic [ACC_W-1:0]  pe_ofm;
    logic              ofm_we;
    logic [OFM_AW-1:0] ofm_addr;
    logic [ACC_W-1:0]  ofm_wdata;

    modport master (
        input  start, pe_ofm,
        output busy, done, ifm_rd, ifm_addr, wgt_rd, wgt_addr,
               pe_acc_clr, pe_mac_en, ofm_we, ofm_addr, ofm_wdata
    );

    modport slave (
        output start, pe_ofm,
        input  busy, done, ifm_rd, ifm_addr, wgt_rd, wgt_addr,
               pe_acc_clr, pe_mac_en, ofm_we, ofm_addr, ofm_wdata
    );

endinterface

// File: rtl/conv_loop_counter.sv
// Six-deep loop nest (f, r, c, ch, ky, kx) with incremental IFM/weight/OFM address generation.
module conv_loop_counter
    import pe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [IFM_AW-1:0] ifm_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic [OFM_AW-1:0] pix_addr,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last
);

    localparam int KW  = $clog2(K);
    localparam int CHW = $clog2(CIN);
    localparam int XW  = $clog2(OUT_W);
    localparam int YW  = $clog2(OUT_H);
    localparam int FW  = $clog2(COUT);

    // Address jumps taken when an inner counter wraps into its parent.
    localparam logic [IFM_AW-1:0] STEP_KY  = IFM_AW'(IMG_W - (K - 1));
    localparam logic [IFM_AW-1:0] STEP_CH  = IFM_AW'(PLANE - (K - 1) * IMG_W - (K - 1));
    localparam logic [IFM_AW-1:0] STEP_ROW = IFM_AW'(IMG_W - OUT_W + 1);
    localparam logic [WGT_AW-1:0] WGT_REW  = WGT_AW'(MACS_PER_PIX - 1);

    logic [KW-1:0]     kx, ky;
    logic [CHW-1:0]    ch;
    logic [XW-1:0]     c;
    logic [YW-1:0]     r;
    logic [FW-1:0]     f;
    logic [IFM_AW-1:0] pix_base;
    logic              kx_end, ky_end, ch_end, c_end, r_end, f_end;

    assign kx_end = (kx == KW'(K - 1));
    assign ky_end = (ky == KW'(K - 1));
    assign ch_end = (ch == CHW'(CIN - 1));
    assign c_end  = (c == XW'(OUT_W - 1));
    assign r_end  = (r == YW'(OUT_H - 1));
    assign f_end  = (f == FW'(COUT - 1));

    assign first_tap = (kx == '0) && (ky == '0) && (ch == '0);
    assign last_tap  = kx_end && ky_end && ch_end;
    assign last      = last_tap && c_end && r_end && f_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kx       <= '0;
            ky       <= '0;
            ch       <= '0;
            c        <= '0;
            r        <= '0;
            f        <= '0;
            pix_base <= '0;
            ifm_addr <= '0;
            wgt_addr <= '0;
            pix_addr <= '0;
        end else if (en) begin
            if (!kx_end) begin
                kx       <= kx + KW'(1);
                ifm_addr <= ifm_addr + IFM_AW'(1);
                wgt_addr <= wgt_addr + WGT_AW'(1);
            end else begin
                kx <= '0;
                if (!ky_end) begin
                    ky       <= ky + KW'(1);
                    ifm_addr <= ifm_addr + STEP_KY;
                    wgt_addr <= wgt_addr + WGT_AW'(1);
                end else begin
                    ky <= '0;
                    if (!ch_end) begin
                        ch       <= ch + CHW'(1);
                        ifm_addr <= ifm_addr + STEP_CH;
                        wgt_addr <= wgt_addr + WGT_AW'(1);
                    end else begin
                        // Pixel boundary: output pixels are contiguous across c, r and f.
                        ch       <= '0;
                        pix_addr <= last ? '0 : pix_addr + OFM_AW'(1);
                        if (!c_end) begin
                            c        <= c + XW'(1);
                            pix_base <= pix_base + IFM_AW'(1);
                            ifm_addr <= pix_base + IFM_AW'(1);
                            wgt_addr <= wgt_addr - WGT_REW;
                        end else begin
                            c <= '0;
                            if (!r_end) begin
                                r        <= r + YW'(1);
                                pix_base <= pix_base + STEP_ROW;
                                ifm_addr <= pix_base + STEP_ROW;
                                wgt_addr <= wgt_addr - WGT_REW;
                            end else begin
                                r        <= '0;
                                pix_base <= '0;
                                ifm_addr <= '0;
                                if (!f_end) begin
                                    f        <= f + FW'(1);
                                    wgt_addr <= wgt_addr + WGT_AW'(1);
                                end else begin
                                    f        <= '0;
                                    wgt_addr <= '0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pe_conv_sequencer.sv
// Layer-level FSM plus PE/OFM writeback pipeline driving one 8-bit MAC PE through a 3x3 conv.
module pe_conv_sequencer
    import pe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pe_conv_sequencer_if.master   bus,
    output state_t                dbg_state
);

    state_t state, state_next;

    logic              run;
    logic [OFM_AW-1:0] pix_addr;
    logic              first_tap, last_tap, last;

    logic              mac_en_q, acc_clr_q, mac_last_q;
    logic [OFM_AW-1:0] mac_pix_q;
    logic [PE_LAT-1:0]             we_pipe;
    logic [PE_LAT-1:0][OFM_AW-1:0] addr_pipe;

    assign run = (state == S_RUN);

    conv_loop_counter u_loop (
        .clk       (clk),
        .rst       (rst),
        .en        (run),
        .ifm_addr  (bus.ifm_addr),
        .wgt_addr  (bus.wgt_addr),
        .pix_addr  (pix_addr),
        .first_tap (first_tap),
        .last_tap  (last_tap),
        .last      (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (last) state_next = S_DRAIN;
            S_DRAIN: if (bus.ofm_we) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // MAC strobes trail the reads by the SRAM latency; writeback trails the last tap by PE_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            mac_pix_q  <= '0;
            we_pipe    <= '0;
            addr_pipe  <= '0;
        end else begin
            mac_en_q   <= run;
            acc_clr_q  <= run && first_tap;
            mac_last_q <= run && last_tap;
            if (run && last_tap) mac_pix_q <= pix_addr;
            we_pipe[0] <= mac_last_q;
            if (mac_last_q) addr_pipe[0] <= mac_pix_q;
            for (int i = 1; i < PE_LAT; i++) begin
                we_pipe[i]   <= we_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign bus.busy       = (state == S_RUN) || (state == S_DRAIN);
    assign bus.done       = (state == S_DONE);
    assign bus.ifm_rd     = run;
    assign bus.wgt_rd     = run;
    assign bus.pe_mac_en  = mac_en_q;
    assign bus.pe_acc_clr = acc_clr_q;
    assign bus.ofm_we     = we_pipe[PE_LAT-1];
    assign bus.ofm_addr   = addr_pipe[PE_LAT-1];
    assign bus.ofm_wdata  = bus.ofm_we ? bus.pe_ofm : '0;
    assign dbg_state      = state;

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Directed bench for pe_conv_sequencer: SRAM and PE models, golden OFM scoreboard, cycle-exact address checks.
module tb_pe_conv_sequencer;
    import pe_ctrl_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    pe_conv_sequencer_if bus_if ();

    pe_conv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // SRAM and PE models
    logic [7:0]       ifm_mem [CIN*PLANE];
    logic [7:0]       wgt_mem [COUT*MACS_PER_PIX];
    logic [7:0]       ifm_q = '0;
    logic [7:0]       wgt_q = '0;
    logic [ACC_W-1:0] acc   = '0;
    logic [ACC_W-1:0] prod;

    assign prod          = ACC_W'(ifm_q) * ACC_W'(wgt_q);
    assign bus_if.pe_ofm = acc;

    always @(posedge clk) begin
        if (bus_if.ifm_rd) ifm_q <= ifm_mem[bus_if.ifm_addr];
        if (bus_if.wgt_rd) wgt_q <= wgt_mem[bus_if.wgt_addr];
        if (bus_if.pe_mac_en) acc <= bus_if.pe_acc_clr ? prod : acc + prod;
    end

    // Scoreboard
    int               n_vec = 0;
    int               n_err = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic             mon_en = 1'b0;
    int               wr_count = 0;
    int               done_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus_if.busy, bus_if.done, bus_if.ifm_rd, bus_if.ifm_addr, bus_if.wgt_rd,
                    bus_if.wgt_addr, bus_if.pe_acc_clr, bus_if.pe_mac_en, bus_if.ofm_we,
                    bus_if.ofm_addr, bus_if.ofm_wdata});
    endfunction

    function automatic logic [63:0] ctrl();
        return 64'({bus_if.ifm_rd, bus_if.wgt_rd, bus_if.busy, bus_if.done,
                    bus_if.pe_mac_en, bus_if.pe_acc_clr});
    endfunction

    always @(negedge clk) begin
        if (bus_if.done) done_count++;
        if (mon_en && bus_if.ofm_we) begin
            logic [ACC_W-1:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("ofm_addr", 64'(bus_if.ofm_addr), 64'(wr_count));
            check("ofm_wdata", 64'(bus_if.ofm_wdata), 64'(e));
            wr_count++;
        end
    end

    initial begin
        int               n;
        logic             prev_first;
        logic [ACC_W-1:0] pix0;

        bus_if.start = 1'b0;
        foreach (ifm_mem[i]) ifm_mem[i] = 8'($urandom_range(0, 255));
        foreach (wgt_mem[i]) wgt_mem[i] = 8'($urandom_range(0, 255));
        for (int f = 0; f < COUT; f++)
            for (int r = 0; r < OUT_H; r++)
                for (int c = 0; c < OUT_W; c++) begin
                    logic [ACC_W-1:0] s;
                    s = '0;
                    for (int ch = 0; ch < CIN; ch++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++)
                                s += ACC_W'(ifm_mem[ch*PLANE + (r+ky)*IMG_W + c + kx]) *
                                     ACC_W'(wgt_mem[f*MACS_PER_PIX + ch*K*K + ky*K + kx]);
                    exp_q.push_back(s);
                end
        pix0 = exp_q[0];

        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_outputs", outs(), 64'(0));
        check("idle_state", 64'(dbg_state), 64'(S_IDLE));

        // Partial run: hand-computed addresses, then asynchronous reset at cycle 1000
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        n = 1;
        while (n < 1000) begin
            case (n)
                1: begin
                    check("c1_ifm", 64'(bus_if.ifm_addr), 64'(0));
                    check("c1_wgt", 64'(bus_if.wgt_addr), 64'(0));
                    check("c1_ctrl", ctrl(), 64'(6'b111000));
                end
                2: begin
                    check("c2_ifm", 64'(bus_if.ifm_addr), 64'(1));
                    check("c2_wgt", 64'(bus_if.wgt_addr), 64'(1));
                    check("c2_ctrl", ctrl(), 64'(6'b111011));
                end
                3: begin
                    check("c3_ifm", 64'(bus_if.ifm_addr), 64'(2));
                    check("c3_wgt", 64'(bus_if.wgt_addr), 64'(2));
                    check("c3_ctrl", ctrl(), 64'(6'b111010));
                end
                4: begin
                    check("c4_ifm", 64'(bus_if.ifm_addr), 64'(32));
                    check("c4_wgt", 64'(bus_if.wgt_addr), 64'(3));
                end
                10: begin
                    check("tap9_ifm", 64'(bus_if.ifm_addr), 64'(1024));
                    check("tap9_wgt", 64'(bus_if.wgt_addr), 64'(9));
                end
                28: begin
                    check("pix1_ifm", 64'(bus_if.ifm_addr), 64'(1));
                    check("pix1_wgt", 64'(bus_if.wgt_addr), 64'(0));
                    check("c28_we", 64'(bus_if.ofm_we), 64'(0));
                end
                29: begin
                    check("c29_we", 64'(bus_if.ofm_we), 64'(1));
                    check("c29_ofm_addr", 64'(bus_if.ofm_addr), 64'(0));
                    check("c29_wdata", 64'(bus_if.ofm_wdata), 64'(pix0));
                    check("c29_clr", 64'(bus_if.pe_acc_clr), 64'(1));
                end
                811: begin
                    check("row_wrap_ifm", 64'(bus_if.ifm_addr), 64'(32));
                    check("row_wrap_wgt", 64'(bus_if.wgt_addr), 64'(0));
                end
                default: ;
            endcase
            @(negedge clk);
            n++;
        end
        check("pre_rst_busy", 64'(bus_if.busy), 64'(1));
        rst = 1'b1;
        #1;
        check("async_rst_outputs", outs(), 64'(0));
        check("async_rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_outputs", outs(), 64'(0));
        check("no_partial_done", 64'(done_count), 64'(0));

        // Full layer: every issue cycle checked against the loop-nest formula
        mon_en = 1'b1;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        n = 1;
        prev_first = 1'b0;
        for (int f = 0; f < COUT; f++)
            for (int r = 0; r < OUT_H; r++)
                for (int c = 0; c < OUT_W; c++)
                    for (int ch = 0; ch < CIN; ch++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++) begin
                                check("run_ifm", 64'(bus_if.ifm_addr), 64'(ch*PLANE + (r+ky)*IMG_W + c + kx));
                                check("run_wgt", 64'(bus_if.wgt_addr), 64'(f*MACS_PER_PIX + ch*K*K + ky*K + kx));
                                check("run_ctrl", ctrl(), 64'({4'b1110, n >= 2, prev_first}));
                                prev_first = (ch == 0) && (ky == 0) && (kx == 0);
                                bus_if.start = (n == 100) || (n == 5000);
                                @(negedge clk);
                                n++;
                            end
        bus_if.start = 1'b0;
        check("drain_cycle", 64'(n), 64'(72901));
        check("drain_ctrl", ctrl(), 64'(6'b001010));
        check("drain_state", 64'(dbg_state), 64'(S_DRAIN));
        @(negedge clk);
        check("last_we_ctrl", ctrl(), 64'(6'b001000));
        check("last_we", 64'(bus_if.ofm_we), 64'(1));
        check("last_we_addr", 64'(bus_if.ofm_addr), 64'(2699));
        @(negedge clk);
        check("done_ctrl", ctrl(), 64'(6'b000100));
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("after_done_ctrl", ctrl(), 64'(6'b000000));
        check("after_done_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        check("start_in_done_ignored", 64'(bus_if.busy), 64'(0));
        check("end_ifm_addr", 64'(bus_if.ifm_addr), 64'(0));
        check("end_wgt_addr", 64'(bus_if.wgt_addr), 64'(0));
        check("write_count", 64'(wr_count), 64'(COUT*OUT_H*OUT_W));
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("done_count", 64'(done_count), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_conv_sequencer.md
Name: pe_conv_sequencer

Overview:
Sequences a single 8-bit MAC PE through a full 3x3 valid convolution: 32x32x3 IFM, 3 filters, 30x30x3 OFM. Generates IFM and weight buffer read addresses, PE accumulate-clear and MAC-enable strobes, and OFM buffer write strobes with addresses. Sits between the top-level start/done control and the IFM/weight/OFM SRAMs plus the PE, one output pixel per 27 MAC cycles, issued back-to-back.

Parameters:
IMG_W, 32, input width
IMG_H, 32, input height
K, 3, kernel side
CIN, 3, input channels
COUT, 3, filters
ACC_W, 16, PE output width
IFM_AW, 12, IFM address width (covers CIN*IMG_H*IMG_W=3072)
WGT_AW, 7, weight address width (covers COUT*CIN*K*K=81)
OFM_AW, 12, OFM address width (covers COUT*30*30=2700)
PE_LAT, 1, cycles from last pe_mac_en to valid pe_ofm

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a layer when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final OFM write
ifm_rd  out  1  IFM SRAM read enable
ifm_addr  out  IFM_AW  IFM read address
wgt_rd  out  1  weight SRAM read enable
wgt_addr  out  WGT_AW  weight read address
pe_acc_clr  out  1  PE loads product instead of accumulating
pe_mac_en  out  1  PE performs MAC this cycle
pe_ofm  in  ACC_W  PE accumulator output
ofm_we  out  1  OFM SRAM write enable
ofm_addr  out  OFM_AW  OFM write address
ofm_wdata  out  ACC_W  OFM write data

Behaviour:
- Reset values: busy=0, done=0, all read/write enables, pe_acc_clr, pe_mac_en =0; all addresses and ofm_wdata =0; FSM=IDLE; all counters=0.
- FSM: IDLE -(start)-> RUN -(last MAC address issued)-> DRAIN -(last ofm_we)-> DONE -(1 cycle)-> IDLE. start outside IDLE ignored.
- Loop nest, outer to inner: f (0..COUT-1), r (0..IMG_H-K), c (0..IMG_W-K), ch, ky, kx; each innermost step is one cycle in RUN, no bubbles.
- ifm_addr = ch*IMG_H*IMG_W + (r+ky)*IMG_W + (c+kx); wgt_addr = f*CIN*K*K + ch*K*K + ky*K + kx; all registered outputs. Incremental or multiplier form permitted; results must match exactly.
- ifm_rd=wgt_rd=1 on every RUN cycle. SRAMs have 1-cycle read latency: pe_mac_en asserted exactly 1 cycle after each read; pe_acc_clr high with pe_mac_en for the (ch,ky,kx)=(0,0,0) tap only.
- Writeback: ofm_we asserted PE_LAT cycles after the pe_mac_en of tap (CIN-1,K-1,K-1); ofm_wdata = pe_ofm that cycle; ofm_addr = f*(IMG_H-K+1)*(IMG_W-K+1) + r*(IMG_W-K+1) + c of that pixel (pipelined alongside).
- Throughput: one ofm_we every CIN*K*K=27 cycles; writeback of pixel N overlaps issue of pixel N+1.
- Latency: first ifm_rd the cycle after start accepted; total start-to-done = 72900 + 1 + PE_LAT + 1 cycles at defaults.
- busy rises the cycle after start, falls with done.
- Counter wrap: kx->ky->ch->c->r->f carry chain; final carry out of f ends RUN; counters return to 0.
- Reset mid-operation: all outputs drop to reset values immediately; no partial done; in-flight writes discarded.
- start coincident with done cycle: ignored (FSM not IDLE).

Decomposition:
- Shared package pe_ctrl_pkg: FSM state enum, default geometry constants (IMG_W, IMG_H, K, CIN, COUT), derived OUT_W/OUT_H, MACS_PER_PIX.
- One sub-module: conv_loop_counter (nested counters + carry/last flags + incremental address generation); top holds FSM and writeback pipeline.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0, no enables.
- start pulse -> first 3 cycles ifm_addr=0,1,2, wgt_addr=0,1,2; 4th ifm_addr=32; tap 9 ifm_addr=1024; pe_acc_clr only on first pe_mac_en.
- Full layer with golden model (random IFM/weights, behavioural PE) -> 2700 ofm_we, addresses 0..2699 in order, data matches; done exactly once at cycle 72900+PE_LAT+2 after start.
- Pixel boundary: 28th read -> ifm_addr=1 (c=1), wgt_addr=0; row wrap after pixel c=29 -> next ifm_addr=32; filter wrap -> wgt_addr=27 at issue cycle 24300.
- start asserted while busy at cycles 100 and 5000 -> ignored, sequence and done count unchanged.
- rst asserted at cycle 1000 -> outputs zero asynchronously; new start afterward -> full correct run from ifm_addr=0.
